axi_rw: RTL and testbench

Single-outstanding bridge between the core's memory-access port and an AXI4-Lite master interface. It sits between the core's data path, the load/store unit, and the SoC memory or UART side, replacing the zero-latency RAM model with a handshaked bus. It converts one core read or write of 1/2/4/8 bytes into AR/R or AW/W/B transactions. It returns lane-aligned read data and the bus response.

---
 rtl/axi_rw_pkg.sv | 32 +++
 rtl/axi_rw_lane_align.sv | 33 +++
 rtl/axi_rw.sv | 161 ++++++++++++++++
 tb/tb_axi_rw.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/axi_rw_pkg.sv
// Shared constants for the axi_rw bridge: bus widths, size/response codes,
// FSM state encodings and the natural-alignment helper.
package axi_rw_pkg;

  localparam int AXI_ADDR_BUS = 64;
  localparam int AXI_DATA_BUS = 64;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;
  localparam logic [1:0] SIZE_D = 2'd3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RD_ADDR = 3'd1;
  localparam logic [2:0] ST_RD_DATA = 3'd2;
  localparam logic [2:0] ST_WR_REQ  = 3'd3;
  localparam logic [2:0] ST_WR_RESP = 3'd4;

  // Low address bits that must be zero for an access of the given size.
  function automatic logic [2:0] size_align_mask(input logic [1:0] size);
    case (size)
      SIZE_B:  return 3'b000;
      SIZE_H:  return 3'b001;
      SIZE_W:  return 3'b011;
      default: return 3'b111;
    endcase
  endfunction

endpackage

// File: rtl/axi_rw_lane_align.sv
// Combinational byte-lane alignment: write strobes, lane-shifted write data
// and right-aligned, size-masked read data. Bytes shifted past lane 7 drop.
module axi_rw_lane_align
  import axi_rw_pkg::*;
(
  input  logic [2:0]  lane,
  input  logic [1:0]  size,
  input  logic [63:0] wdata,
  input  logic [63:0] rdata_beat,
  output logic [7:0]  strb,
  output logic [63:0] wdata_lane,
  output logic [63:0] rdata_out
);

  logic [7:0]  strb_base;
  logic [63:0] size_mask;

  always_comb begin
    strb_base = 8'hFF;
    size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
    case (size)
      SIZE_B: begin strb_base = 8'h01; size_mask = 64'h0000_0000_0000_00FF; end
      SIZE_H: begin strb_base = 8'h03; size_mask = 64'h0000_0000_0000_FFFF; end
      SIZE_W: begin strb_base = 8'h0F; size_mask = 64'h0000_0000_FFFF_FFFF; end
      default: ;
    endcase
  end

  assign strb       = strb_base << lane;
  assign wdata_lane = wdata << {lane, 3'b000};
  assign rdata_out  = (rdata_beat >> {lane, 3'b000}) & size_mask;

endmodule

// File: rtl/axi_rw.sv
// Single-outstanding bridge from the core memory port to AXI4-Lite.
// Optional AXI_ALIGN_CHECK_EN: misaligned accesses complete locally with SLVERR.
module axi_rw
  import axi_rw_pkg::*;
#(
  parameter int ADDR_W = AXI_ADDR_BUS,
  parameter int DATA_W = AXI_DATA_BUS
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rw_valid_i,
  input  logic              rw_req_i,
  input  logic [ADDR_W-1:0] rw_addr_i,
  input  logic [1:0]        rw_size_i,
  input  logic [DATA_W-1:0] rw_w_data_i,
  output logic              rw_ready_o,
  output logic [DATA_W-1:0] rw_r_data_o,
  output logic [1:0]        rw_resp_o,
  output logic              aw_valid_o,
  input  logic              aw_ready_i,
  output logic [ADDR_W-1:0] aw_addr_o,
  output logic              w_valid_o,
  input  logic              w_ready_i,
  output logic [DATA_W-1:0] w_data_o,
  output logic [7:0]        w_strb_o,
  input  logic              b_valid_i,
  output logic              b_ready_o,
  input  logic [1:0]        b_resp_i,
  output logic              ar_valid_o,
  input  logic              ar_ready_i,
  output logic [ADDR_W-1:0] ar_addr_o,
  input  logic              r_valid_i,
  output logic              r_ready_o,
  input  logic [DATA_W-1:0] r_data_i,
  input  logic [1:0]        r_resp_i
);

  logic [2:0]  state;
  logic [2:0]  lane_q;
  logic [1:0]  size_q;
  logic        aw_done;
  logic        w_done;
  logic        aw_hs;
  logic        w_hs;
  logic [2:0]  lane_sel;
  logic [1:0]  size_sel;
  logic [7:0]  lane_strb;
  logic [63:0] lane_wdata;
  logic [63:0] lane_rdata;

  // Write alignment uses the live request in IDLE; read extraction uses the
  // latched lane/size once the request has been accepted.
  assign lane_sel = (state == ST_IDLE) ? rw_addr_i[2:0] : lane_q;
  assign size_sel = (state == ST_IDLE) ? rw_size_i      : size_q;

  axi_rw_lane_align u_lane_align (
    .lane       (lane_sel),
    .size       (size_sel),
    .wdata      (rw_w_data_i),
    .rdata_beat (r_data_i),
    .strb       (lane_strb),
    .wdata_lane (lane_wdata),
    .rdata_out  (lane_rdata)
  );

  assign aw_hs     = aw_valid_o & aw_ready_i;
  assign w_hs      = w_valid_o & w_ready_i;
  assign r_ready_o = (state == ST_RD_DATA);
  assign b_ready_o = (state == ST_WR_RESP);

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      lane_q      <= 3'd0;
      size_q      <= SIZE_B;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      rw_ready_o  <= 1'b0;
      rw_r_data_o <= '0;
      rw_resp_o   <= RESP_OKAY;
      aw_valid_o  <= 1'b0;
      aw_addr_o   <= '0;
      w_valid_o   <= 1'b0;
      w_data_o    <= '0;
      w_strb_o    <= 8'h00;
      ar_valid_o  <= 1'b0;
      ar_addr_o   <= '0;
    end else begin
      rw_ready_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (rw_valid_i) begin
            lane_q <= rw_addr_i[2:0];
            size_q <= rw_size_i;
`ifdef AXI_ALIGN_CHECK_EN
            if (|(rw_addr_i[2:0] & size_align_mask(rw_size_i))) begin
              rw_ready_o  <= 1'b1;
              rw_resp_o   <= RESP_SLVERR;
              rw_r_data_o <= '0;
            end else
`endif
            if (rw_req_i) begin
              state      <= ST_WR_REQ;
              aw_valid_o <= 1'b1;
              w_valid_o  <= 1'b1;
              aw_addr_o  <= {rw_addr_i[ADDR_W-1:3], 3'b000};
              w_data_o   <= lane_wdata;
              w_strb_o   <= lane_strb;
              aw_done    <= 1'b0;
              w_done     <= 1'b0;
            end else begin
              state      <= ST_RD_ADDR;
              ar_valid_o <= 1'b1;
              ar_addr_o  <= {rw_addr_i[ADDR_W-1:3], 3'b000};
            end
          end
        end
        ST_RD_ADDR: begin
          if (ar_ready_i) begin
            ar_valid_o <= 1'b0;
            state      <= ST_RD_DATA;
          end
        end
        ST_RD_DATA: begin
          if (r_valid_i) begin
            rw_ready_o  <= 1'b1;
            rw_r_data_o <= lane_rdata;
            rw_resp_o   <= r_resp_i;
            state       <= ST_IDLE;
          end
        end
        ST_WR_REQ: begin
          if (aw_hs) begin
            aw_valid_o <= 1'b0;
            aw_done    <= 1'b1;
          end
          if (w_hs) begin
            w_valid_o <= 1'b0;
            w_done    <= 1'b1;
          end
          // Both channels may finish in the same cycle, so count this cycle's handshakes.
          if ((aw_done | aw_hs) & (w_done | w_hs)) begin
            state   <= ST_WR_RESP;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
          end
        end
        ST_WR_RESP: begin
          if (b_valid_i) begin
            rw_ready_o  <= 1'b1;
            rw_r_data_o <= '0;
            rw_resp_o   <= b_resp_i;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_rw.sv
// Randomized self-checking bench for axi_rw with a byte-level reference model
// and a wait-state-programmable AXI-Lite slave.
module tb_axi_rw;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        rw_valid_i = 1'b0;
  logic        rw_req_i = 1'b0;
  logic [63:0] rw_addr_i = '0;
  logic [1:0]  rw_size_i = '0;
  logic [63:0] rw_w_data_i = '0;
  logic        rw_ready_o;
  logic [63:0] rw_r_data_o;
  logic [1:0]  rw_resp_o;
  logic        aw_valid_o;
  logic        aw_ready_i = 1'b0;
  logic [63:0] aw_addr_o;
  logic        w_valid_o;
  logic        w_ready_i = 1'b0;
  logic [63:0] w_data_o;
  logic [7:0]  w_strb_o;
  logic        b_valid_i = 1'b0;
  logic        b_ready_o;
  logic [1:0]  b_resp_i = '0;
  logic        ar_valid_o;
  logic        ar_ready_i = 1'b0;
  logic [63:0] ar_addr_o;
  logic        r_valid_i = 1'b0;
  logic        r_ready_o;
  logic [63:0] r_data_i = '0;
  logic [1:0]  r_resp_i = '0;

  int tests = 0;
  int errors = 0;

  always #5 clock = ~clock;

  axi_rw dut (
    .clock(clock), .reset(reset),
    .rw_valid_i(rw_valid_i), .rw_req_i(rw_req_i), .rw_addr_i(rw_addr_i),
    .rw_size_i(rw_size_i), .rw_w_data_i(rw_w_data_i),
    .rw_ready_o(rw_ready_o), .rw_r_data_o(rw_r_data_o), .rw_resp_o(rw_resp_o),
    .aw_valid_o(aw_valid_o), .aw_ready_i(aw_ready_i), .aw_addr_o(aw_addr_o),
    .w_valid_o(w_valid_o), .w_ready_i(w_ready_i), .w_data_o(w_data_o), .w_strb_o(w_strb_o),
    .b_valid_i(b_valid_i), .b_ready_o(b_ready_o), .b_resp_i(b_resp_i),
    .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready_i), .ar_addr_o(ar_addr_o),
    .r_valid_i(r_valid_i), .r_ready_o(r_ready_o), .r_data_i(r_data_i), .r_resp_i(r_resp_i)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: byte-by-byte placement, independent of shift/mask tricks.
  function automatic int nbytes(input logic [1:0] size);
    return 1 << size;
  endfunction

  function automatic logic [7:0] m_strb(input logic [2:0] lane, input logic [1:0] size);
    logic [7:0] s = 8'h00;
    for (int i = 0; i < 8; i++)
      if (i >= int'(lane) && i < int'(lane) + nbytes(size)) s[i] = 1'b1;
    return s;
  endfunction

  function automatic logic [63:0] m_wdata(input logic [2:0] lane, input logic [63:0] wd);
    logic [63:0] o = '0;
    for (int i = 0; i < 8; i++)
      if (i >= int'(lane)) o[8*i +: 8] = wd[8*(i-int'(lane)) +: 8];
    return o;
  endfunction

  function automatic logic [63:0] m_rdata(input logic [2:0] lane, input logic [1:0] size,
                                          input logic [63:0] rd);
    logic [63:0] o = '0;
    for (int j = 0; j < 8; j++)
      if (j < nbytes(size) && int'(lane) + j < 8) o[8*j +: 8] = rd[8*(int'(lane)+j) +: 8];
    return o;
  endfunction

  function automatic logic [11:0] outs_active();
    return {rw_ready_o, |rw_r_data_o, |rw_resp_o, aw_valid_o, |aw_addr_o, w_valid_o,
            |w_data_o, |w_strb_o, b_ready_o, ar_valid_o, |ar_addr_o, r_ready_o};
  endfunction

  // Called just after a clock edge with the DUT in IDLE; returns in the
  // rw_ready_o cycle so a following call presents a back-to-back request.
  task automatic run_txn(input string nm, input bit wr, input logic [63:0] addr,
                         input logic [1:0] size, input logic [63:0] wd,
                         input logic [63:0] rd, input logic [1:0] rresp, input logic [1:0] bresp,
                         input int arw, input int aww, input int ww, input int rwt, input int bw);
    int ar_cnt = 0, aw_cnt = 0, w_cnt = 0, r_cnt = 0, b_cnt = 0;
    int ar_hs = 0, aw_hs = 0, w_hs = 0, r_hs = 0, b_hs = 0;
    int lat = -1, exp_lat;
    bit overlap = 0, misal, local_err;
    logic [63:0] got_rd = '0, got_awaddr = '0, got_araddr = '0, got_wdata = '0;
    logic [7:0]  got_strb = '0;
    logic [1:0]  got_resp = '0;
    logic [63:0] exp_rd;
    logic [1:0]  exp_resp;
    logic [39:0] exp_hs;

    rw_valid_i = 1'b1; rw_req_i = wr; rw_addr_i = addr; rw_size_i = size; rw_w_data_i = wd;
    @(posedge clock); #1;
    rw_valid_i = 1'b0;
    rw_addr_i = {$urandom, $urandom};
    rw_w_data_i = {$urandom, $urandom};
    rw_size_i = 2'($urandom);
    for (int cyc = 1; cyc <= 80; cyc++) begin
      if (ar_valid_o && (aw_valid_o || w_valid_o)) overlap = 1;
      ar_ready_i = ar_valid_o && ar_cnt >= arw;
      aw_ready_i = aw_valid_o && aw_cnt >= aww;
      w_ready_i  = w_valid_o && w_cnt >= ww;
      r_valid_i  = r_ready_o && r_cnt >= rwt;
      b_valid_i  = b_ready_o && b_cnt >= bw;
      r_data_i   = r_valid_i ? rd : {$urandom, $urandom};
      r_resp_i   = rresp;
      b_resp_i   = bresp;
      if (ar_valid_o) ar_cnt++;
      if (aw_valid_o) aw_cnt++;
      if (w_valid_o)  w_cnt++;
      if (r_ready_o)  r_cnt++;
      if (b_ready_o)  b_cnt++;
      if (ar_valid_o && ar_ready_i) begin ar_hs++; got_araddr = ar_addr_o; end
      if (aw_valid_o && aw_ready_i) begin aw_hs++; got_awaddr = aw_addr_o; end
      if (w_valid_o && w_ready_i) begin w_hs++; got_wdata = w_data_o; got_strb = w_strb_o; end
      if (r_valid_i) r_hs++;
      if (b_valid_i) b_hs++;
      if (rw_ready_o) begin
        lat = cyc; got_rd = rw_r_data_o; got_resp = rw_resp_o;
        break;
      end
      @(posedge clock); #1;
    end
    ar_ready_i = 0; aw_ready_i = 0; w_ready_i = 0; r_valid_i = 0; b_valid_i = 0;

    misal = (int'(addr[2:0]) % nbytes(size)) != 0;
`ifdef AXI_ALIGN_CHECK_EN
    if (misal) begin
      exp_lat = 1; exp_rd = '0; exp_resp = 2'b10; exp_hs = '0;
    end else
`endif
    if (wr) begin
      exp_lat = 3 + ((aww > ww) ? aww : ww) + bw;
      exp_rd = '0; exp_resp = bresp;
      exp_hs = {8'd0, 8'd0, 8'd1, 8'd1, 8'd1};
      check({nm, ".aw_addr"}, got_awaddr, {addr[63:3], 3'b000});
      check({nm, ".w_strb"}, 64'(got_strb), 64'(m_strb(addr[2:0], size)));
      check({nm, ".w_data"}, got_wdata, m_wdata(addr[2:0], wd));
    end else begin
      exp_lat = 3 + arw + rwt;
      exp_rd = m_rdata(addr[2:0], size, rd); exp_resp = rresp;
      exp_hs = {8'd1, 8'd1, 8'd0, 8'd0, 8'd0};
      check({nm, ".ar_addr"}, got_araddr, {addr[63:3], 3'b000});
    end
    local_err = (lat < 0);
    check({nm, ".latency"}, 64'(lat), 64'(exp_lat));
    check({nm, ".rdata"}, got_rd, exp_rd);
    check({nm, ".resp"}, 64'(got_resp), 64'(exp_resp));
    check({nm, ".handshakes"}, 64'({8'(ar_hs), 8'(r_hs), 8'(aw_hs), 8'(w_hs), 8'(b_hs)}),
          64'(exp_hs));
    check({nm, ".rd_wr_overlap"}, 64'(overlap), 64'd0);
    if (local_err) begin
      reset = 1; @(posedge clock); #1; reset = 0;
    end
  endtask

  initial begin
    logic [1:0] sz;
    logic [63:0] a;
    repeat (3) @(posedge clock);
    #1;
    check("reset_outputs", 64'(outs_active()), 64'd0);
    reset = 0;

    run_txn("rd_dword", 0, 64'h0000_0000_8000_0010, 2'd3, '0, 64'h1122334455667788,
            2'b00, 2'b00, 0, 0, 0, 0, 0);
    run_txn("wr_byte_bhold", 1, 64'h0000_0000_8000_0005, 2'd0, 64'h0000_0000_0000_00AB, '0,
            2'b00, 2'b00, 0, 0, 0, 0, 4);
    run_txn("wr_w_first", 1, 64'h0000_0000_8000_0020, 2'd2, 64'h0000_0000_CAFE_F00D, '0,
            2'b00, 2'b00, 0, 1, 0, 0, 0);
    run_txn("wr_aw_first", 1, 64'h0000_0000_8000_0028, 2'd3, 64'h0123_4567_89AB_CDEF, '0,
            2'b00, 2'b01, 0, 0, 1, 0, 0);
    run_txn("rd_half_slverr", 0, 64'h0000_0000_8000_0006, 2'd1, '0, 64'hBEEF_0000_0000_0000,
            2'b10, 2'b00, 0, 0, 0, 0, 0);
    run_txn("b2b_rd_a", 0, 64'h0000_0000_8000_0040, 2'd2, '0, 64'hDEAD_BEEF_1234_5678,
            2'b00, 2'b00, 0, 0, 0, 1, 0);
    run_txn("b2b_rd_b", 0, 64'h0000_0000_8000_0044, 2'd2, '0, 64'hDEAD_BEEF_1234_5678,
            2'b00, 2'b00, 0, 0, 0, 0, 0);
    run_txn("rd_word_mis", 0, 64'h0000_0000_8000_0002, 2'd2, '0, 64'hA1A2_A3A4_A5A6_A7A8,
            2'b00, 2'b00, 0, 0, 0, 0, 0);

    // Reset while waiting in the read-data phase.
    @(posedge clock); #1;
    rw_valid_i = 1; rw_req_i = 0; rw_addr_i = 64'h0000_0000_8000_0018; rw_size_i = 2'd3;
    @(posedge clock); #1;
    rw_valid_i = 0; ar_ready_i = 1;
    @(posedge clock); #1;
    ar_ready_i = 0;
    check("mid_rst.in_rd_data", 64'(r_ready_o), 64'd1);
    reset = 1;
    @(posedge clock); #1;
    reset = 0;
    check("mid_rst.outputs", 64'(outs_active()), 64'd0);

    for (int n = 0; n < 40; n++) begin
      sz = 2'($urandom);
      a = {32'h0000_0000, 32'h8000_0000 | ($urandom & 32'h0000_FFFF)};
      if ($urandom_range(0, 3) != 0) a[2:0] = a[2:0] & ~(3'((1 << sz) - 1));
      run_txn($sformatf("rnd%0d", n), 1'($urandom), a, sz, {$urandom, $urandom},
              {$urandom, $urandom}, 2'($urandom), 2'($urandom),
              $urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 2), $urandom_range(0, 2));
      repeat ($urandom_range(0, 2)) begin @(posedge clock); #1; end
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
